// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions used by the fetch/decode queue.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- what decode sees when nothing valid is queued
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One queued fetch result: instruction word, its PC and PC+4 (96 bits)
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for if_id_queue: DEPTH x 96-bit array, one synchronous
// write port, one asynchronous read port, contents never reset.
module if_id_queue_mem
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  if_id_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output if_id_entry_t             rdata
);

    if_id_entry_t mem [DEPTH];

    // Write the incoming entry on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally so decode sees it in the same cycle
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: circular instruction buffer between fetch and decode.
// Optional same-cycle pass-through when empty: define IF_ID_QUEUE_BYPASS_EN.
//
// Handshake: an entry moves across a boundary only in a cycle where the
// producer's valid and the consumer's ready are both high at the rising
// edge; valid never depends on the same-side ready, and ready_IF depends
// only on occupancy (a full queue refuses a push even while it pops).
// flush overrides both handshakes: nothing is pushed or popped that cycle
// and the queue empties on the edge.
module if_id_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   valid_IF,
    input  logic [31:0]            instrCode_IF,
    input  logic [31:0]            PC_IF,
    input  logic [31:0]            PC_4_IF,
    output logic                   ready_IF,
    output logic                   valid_ID,
    input  logic                   ready_ID,
    output logic [31:0]            instrCode_ID,
    output logic [31:0]            PC_ID,
    output logic [31:0]            PC_4_ID,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          store;
    logic          consume;
    if_id_entry_t  wr_entry;
    if_id_entry_t  rd_entry;

    assign empty    = (count == '0);
    assign ready_IF = (count != FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
    // Empty queue forwards a fetched word straight to decode
    assign bypass = empty && valid_IF && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign valid_ID = !empty || bypass;
    assign push     = valid_IF && ready_IF && !flush;
    assign pop      = valid_ID && ready_ID && !flush;
    // A bypassed word taken by decode is never written; one not taken is
    // stored like any other push. A bypassed pop does not drain storage.
    assign store    = push && !(bypass && ready_ID);
    assign consume  = pop && !bypass;
    assign wr_entry = '{instr: instrCode_IF, pc: PC_IF, pc_4: PC_4_IF};

    if_id_queue_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (store),
        .waddr(wp),
        .wdata(wr_entry),
        .raddr(rp),
        .rdata(rd_entry)
    );

    // Pointer and occupancy update; flush discards everything on the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (store) begin
                wp <= wp + 1'b1;
            end
            if (consume) begin
                rp <= rp + 1'b1;
            end
            case ({store, consume})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode-side outputs: bypassed input, head entry, or NOP when empty
    always_comb begin
        instrCode_ID = NOP_INSTR;
        PC_ID        = '0;
        PC_4_ID      = '0;
        if (bypass) begin
            instrCode_ID = instrCode_IF;
            PC_ID        = PC_IF;
            PC_4_ID      = PC_4_IF;
        end else if (!empty) begin
            instrCode_ID = rd_entry.instr;
            PC_ID        = rd_entry.pc;
            PC_4_ID      = rd_entry.pc_4;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
// Honours IF_ID_QUEUE_BYPASS_EN the same way as the design.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int W = 96;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic                   valid_IF = 1'b0;
    logic [31:0]            instrCode_IF = '0;
    logic [31:0]            PC_IF = '0;
    logic [31:0]            PC_4_IF = '0;
    logic                   ready_IF;
    logic                   valid_ID;
    logic                   ready_ID = 1'b0;
    logic [31:0]            instrCode_ID;
    logic [31:0]            PC_ID;
    logic [31:0]            PC_4_ID;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  got_instr[$];
    logic [31:0]  got_pc4[$];
    logic [31:0]  want[$];
    logic         seen_dead = 1'b0;

    logic         m_byp;
    logic         m_push;
    logic         m_pop;
    logic [W-1:0] head;
    logic [W-1:0] dropped;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid_IF    (valid_IF),
        .instrCode_IF(instrCode_IF),
        .PC_IF       (PC_IF),
        .PC_4_IF     (PC_4_IF),
        .ready_IF    (ready_IF),
        .valid_ID    (valid_ID),
        .ready_ID    (ready_ID),
        .instrCode_ID(instrCode_ID),
        .PC_ID       (PC_ID),
        .PC_4_ID     (PC_4_ID),
        .count       (count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of queued entries
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            m_byp  = BYP && (exp_q.size() == 0) && valid_IF;
            m_push = valid_IF && (exp_q.size() < DEPTH);
            m_pop  = (exp_q.size() != 0) && ready_ID;
            if (!(m_byp && ready_ID)) begin
                if (m_pop) dropped = exp_q.pop_front();
                if (m_push) exp_q.push_back({instrCode_IF, PC_IF, PC_4_IF});
            end
        end
    end

    // Compare DUT against the model every cycle and log what decode takes
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_instr, e_pc, e_pc4;
        e_valid = 1'b0;
        e_instr = 32'h0000_0013;
        e_pc    = '0;
        e_pc4   = '0;
        if (BYP && exp_q.size() == 0 && valid_IF && !flush) begin
            e_valid = 1'b1;
            e_instr = instrCode_IF;
            e_pc    = PC_IF;
            e_pc4   = PC_4_IF;
        end else if (exp_q.size() != 0) begin
            head    = exp_q[0];
            e_valid = 1'b1;
            e_instr = head[95:64];
            e_pc    = head[63:32];
            e_pc4   = head[31:0];
        end
        check32("valid_ID", {31'd0, valid_ID}, {31'd0, e_valid});
        check32("instrCode_ID", instrCode_ID, e_instr);
        check32("PC_ID", PC_ID, e_pc);
        check32("PC_4_ID", PC_4_ID, e_pc4);
        check32("ready_IF", {31'd0, ready_IF}, {31'd0, exp_q.size() != DEPTH});
        check32("count", 32'(count), 32'(exp_q.size()));
        if (valid_ID && instrCode_ID == 32'hDEAD_BEEF) seen_dead = 1'b1;
        if (rst && valid_ID && ready_ID && !flush) begin
            got_instr.push_back(instrCode_ID);
            got_pc4.push_back(PC_4_ID);
        end
    end

    // Driver tasks
    task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                          input logic rdy, input logic fl);
        valid_IF     = v;
        instrCode_IF = instr;
        PC_IF        = pc;
        PC_4_IF      = pc + 32'd4;
        ready_ID     = rdy;
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        got_instr.delete();
        got_pc4.delete();
        want.delete();
    endtask

    task automatic check_log(input string name);
        check32({name, "_len"}, 32'(got_instr.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            if (i < got_instr.size()) check32(name, got_instr[i], want[i]);
        end
    endtask

    initial begin
        // Reset state
        #2;
        check32("rst_valid_ID", {31'd0, valid_ID}, 32'd0);
        check32("rst_ready_IF", {31'd0, ready_IF}, 32'd1);
        check32("rst_instr", instrCode_ID, 32'h0000_0013);
        check32("rst_count", 32'(count), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // In-order flow with decode always ready
        clear_logs();
        set_in(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h00A0_0113, 32'h4, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h0020_81B3, 32'h8, 1'b1, 1'b0);
        tick();
        drain(3);
        want.push_back(32'h0050_0093);
        want.push_back(32'h00A0_0113);
        want.push_back(32'h0020_81B3);
        check_log("flow_instr");
        if (got_pc4.size() == 3) begin
            check32("flow_pc4_0", got_pc4[0], 32'h4);
            check32("flow_pc4_1", got_pc4[1], 32'h8);
            check32("flow_pc4_2", got_pc4[2], 32'hC);
        end else begin
            check32("flow_pc4_len", 32'(got_pc4.size()), 32'd3);
        end

        // Fill to full with decode stalled, fifth entry waits
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h1000_0000 + 32'(k), 32'h100 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h1000_0004, 32'h110, 1'b0, 1'b0);
        check32("full_ready_IF", {31'd0, ready_IF}, 32'd0);
        check32("full_count", 32'(count), 32'd4);
        tick();
        check32("full_hold_count", 32'(count), 32'd4);
        check32("full_hold_head", instrCode_ID, 32'h1000_0000);
        set_in(1'b1, 32'h1000_0004, 32'h110, 1'b1, 1'b0);
        tick();
        check32("full_pop_refuse_count", 32'(count), 32'd3);
        tick();
        check32("full_refill_count", 32'(count), 32'd3);
        drain(5);
        for (int k = 0; k < 5; k++) want.push_back(32'h1000_0000 + 32'(k));
        check_log("full_drain");

        // Flush with a wrong-path push in the same cycle
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h2000_0000 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'hDEAD_BEEF, 32'h20C, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check32("flush_count", 32'(count), 32'd0);
        check32("flush_valid_ID", {31'd0, valid_ID}, 32'd0);
        check32("flush_instr", instrCode_ID, 32'h0000_0013);
        drain(3);
        check32("flush_log_len", 32'(got_instr.size()), 32'd0);

        // Steady push+pop at count 2, pointers wrap
        clear_logs();
        set_in(1'b1, 32'h3000_00A0, 32'h300, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h3000_00A1, 32'h304, 1'b0, 1'b0);
        tick();
        want.push_back(32'h3000_00A0);
        want.push_back(32'h3000_00A1);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h3000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            check32("stream_count", 32'(count), 32'd2);
            want.push_back(32'h3000_0000 + 32'(i));
        end
        drain(3);
        check_log("stream");

        // Asynchronous reset with three entries queued
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h4000_0000 + 32'(k), 32'h500 + 32'(4 * k), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check32("arst_valid_ID", {31'd0, valid_ID}, 32'd0);
        check32("arst_count", 32'(count), 32'd0);
        check32("arst_instr", instrCode_ID, 32'h0000_0013);
        check32("arst_pc", PC_ID, 32'h0);
        check32("arst_ready_IF", {31'd0, ready_IF}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        set_in(1'b1, 32'h0010_0093, 32'h600, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check32("post_rst_instr", instrCode_ID, 32'h0010_0093);
        check32("post_rst_pc", PC_ID, 32'h600);
        check32("post_rst_count", 32'(count), 32'd1);
        drain(2);

`ifdef IF_ID_QUEUE_BYPASS_EN
        // Same-cycle pass-through into an empty queue
        set_in(1'b1, 32'h0010_0073, 32'h700, 1'b1, 1'b0);
        #1;
        check32("byp_instr", instrCode_ID, 32'h0010_0073);
        check32("byp_valid_ID", {31'd0, valid_ID}, 32'd1);
        tick();
        check32("byp_count", 32'(count), 32'd0);
        drain(2);
`endif

        check32("no_wrong_path", {31'd0, seen_dead}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
